// File: rtl/soc_clk_gate_ctrl.sv
// Per-domain clock-gating controller: gates each domain after an idle period and
// restores it on request, with an ack once the re-enabled clock has settled.
module soc_clk_gate_ctrl #(
    parameter int unsigned NUM_DOM  = 4,
    parameter int unsigned IDLE_CYC = 16,
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               gate_en,
    input  logic               force_on,
    input  logic [NUM_DOM-1:0] dom_req,
    output logic [NUM_DOM-1:0] clk_en,
    output logic [NUM_DOM-1:0] dom_ack,
    output logic [NUM_DOM-1:0] dom_gated
);

    if (NUM_DOM < 1 || NUM_DOM > 16) begin : g_bad_num_dom
        $error("soc_clk_gate_ctrl: NUM_DOM must be in 1..16");
    end
    if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
        $error("soc_clk_gate_ctrl: CNT_W must be in 1..30");
    end
    if (IDLE_CYC < 1 || longint'(IDLE_CYC) > (longint'(1) << CNT_W)) begin : g_bad_idle
        $error("soc_clk_gate_ctrl: IDLE_CYC-1 does not fit in CNT_W bits");
    end
    if (WAKE_CYC < 1 || longint'(WAKE_CYC) > (longint'(1) << CNT_W)) begin : g_bad_wake
        $error("soc_clk_gate_ctrl: WAKE_CYC-1 does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] IdleLoad = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] WakeLoad = CNT_W'(WAKE_CYC - 1);

    typedef enum logic [1:0] {StOn, StIdleWait, StOff, StWake} state_e;

    state_e           state_q [NUM_DOM];
    state_e           state_d [NUM_DOM];
    logic [CNT_W-1:0] cnt_q   [NUM_DOM];
    logic [CNT_W-1:0] cnt_d   [NUM_DOM];
    logic             allow;

    assign allow = gate_en & ~force_on;

    always_comb begin
        for (int i = 0; i < NUM_DOM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StOn: begin
                    if (!dom_req[i] && allow) begin
                        state_d[i] = StIdleWait;
                        cnt_d[i]   = IdleLoad;
                    end
                end
                StIdleWait: begin
                    // A request at the expiry edge wins over gating.
                    if (dom_req[i] || !allow) begin
                        state_d[i] = StOn;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = StOff;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                StOff: begin
                    if (dom_req[i] || !allow) begin
                        state_d[i] = StWake;
                        cnt_d[i]   = WakeLoad;
                    end
                end
                StWake: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = StOn;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: state_d[i] = StOn;
            endcase
        end
    end

    // Outputs are decoded from the next state so they move with the state flops.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= StOn;
                cnt_q[i]   <= '0;
            end
            clk_en    <= '1;
            dom_ack   <= '1;
            dom_gated <= '0;
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i]   <= state_d[i];
                cnt_q[i]     <= cnt_d[i];
                clk_en[i]    <= (state_d[i] != StOff);
                dom_ack[i]   <= (state_d[i] == StOn) || (state_d[i] == StIdleWait);
                dom_gated[i] <= (state_d[i] == StOff);
            end
        end
    end

endmodule
